harmonic_peak_scan: RTL
=======================

// Module: harmonic_peak_scan
// PURPOSE
//   Downstream consumer of the 4-way harmonic selector mux on the FFT output.
//   On a start pulse, steps the mux select through harmonics 0..3 and samples
//   each re/im pair. Computes the magnitude estimate |re|+|im| for each pair.
//   Reports the strongest harmonic: index, magnitude and raw re/im, with a
//   done pulse.
// PARAMETERS
//   WORD_SIZE  16  width of the re/im samples (two's complement)
// PORTS
//   i_clk            in   1            system clock; all logic on rising edge
//   i_rst            in   1            synchronous, active-high reset
//   i_start          in   1            1-cycle pulse; starts a scan when idle
//   o_select         out  2            drives the mux select input
//   i_harmonic_re    in   WORD_SIZE    mux output, real part (signed)
//   i_harmonic_im    in   WORD_SIZE    mux output, imaginary part (signed)
//   o_busy           out  1            high while a scan is in progress
//   o_done           out  1            1-cycle pulse; results valid
//   o_peak_idx       out  2            index of the strongest harmonic
//   o_peak_mag       out  WORD_SIZE+1  |re|+|im| of the peak (unsigned)
//   o_peak_re        out  WORD_SIZE    re of the peak harmonic
//   o_peak_im        out  WORD_SIZE    im of the peak harmonic
// BEHAVIOUR
//   Reset (sync, i_rst=1 at a clock edge):
//     - state=IDLE.
//     - All outputs 0, including o_select, o_busy and o_done.
//     - Working registers cleared.
//     - Applies in any state; a scan in progress is abandoned and no done fires.
//   FSM states: IDLE -> SCAN -> DONE -> IDLE.
//     IDLE:
//       - o_busy=0, o_select=0.
//       - i_start=1 at an edge -> SCAN with k=0 and o_select=0.
//     SCAN:
//       - o_busy=1. o_select=k (registered).
//       - The mux is combinational, so i_harmonic_* is sampled in the same
//         cycle that o_select=k is driven.
//       - Each cycle: mag = |re| + |im|, computed at WORD_SIZE+1 bits with
//         unsigned abs. abs(-2^(W-1)) = 2^(W-1); no overflow.
//       - The candidate is compared with the best-so-far. Update best if
//         k==0 or mag > best_mag (strict).
//       - Ties keep the lower index.
//       - k increments each cycle. After sampling k==3, go to DONE.
//     DONE (one cycle):
//       - o_done=1, o_busy=1.
//       - o_peak_* are loaded from the best registers at the entry edge, so
//         they are valid while o_done=1.
//       - Next state IDLE.
//   Latency:
//     - i_start sampled at edge E0.
//     - SCAN occupies cycles E0+1 .. E0+4 (o_select = 0,1,2,3).
//     - o_done is high in cycle E0+5.
//     - Back-to-back starts are possible: the earliest next start is sampled
//       in the cycle after done (IDLE).
//   i_start while busy (SCAN or DONE) is ignored; it is not queued.
//   o_peak_* hold the last results until the next DONE or reset. They do not
//     change during a scan.
//   o_select is 0 whenever not in SCAN.
// TESTING
//   1. Reset, then start with inputs (re,im) = (100,0), (-300,50), (20,20),
//      (0,-10) -> done at start+5, idx=1, mag=350, re=-300, im=50.
//   2. All four harmonics (5,-5) (tie, mag=10) -> idx=0, mag=10, re=5, im=-5.
//   3. Harmonic 3 = (-32768,-32768), others 0 -> idx=3, mag=65536 (17'h10000),
//      no overflow.
//   4. Pulse i_start again at start+2 and at start+5 (DONE cycle) -> ignored;
//      exactly one done pulse; o_select sequence is 0,1,2,3.
//   5. Assert i_rst in cycle start+3 -> next cycle busy=0, select=0, all
//      outputs 0; no done pulse follows.
//   6. Two back-to-back scans with different data -> o_peak_* keep scan-1
//      values until scan-2 done, then switch.

Source files
------------

// File: rtl/harmonic_peak_scan.sv
// Scans the four harmonic-selector mux inputs after a start pulse and reports
// the harmonic with the largest |re|+|im| estimate, along with its raw re/im.
module harmonic_peak_scan #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic [1:0]           o_select,
  input  logic [WORD_SIZE-1:0] i_harmonic_re,
  input  logic [WORD_SIZE-1:0] i_harmonic_im,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_peak_idx,
  output logic [WORD_SIZE:0]   o_peak_mag,
  output logic [WORD_SIZE-1:0] o_peak_re,
  output logic [WORD_SIZE-1:0] o_peak_im
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, next_state;

  logic [1:0]           k;
  logic [1:0]           best_idx;
  logic [WORD_SIZE:0]   best_mag;
  logic [WORD_SIZE-1:0] best_re;
  logic [WORD_SIZE-1:0] best_im;

  logic [WORD_SIZE:0]   re_ext, im_ext, abs_re, abs_im, cand_mag;
  logic                 take;
  logic [1:0]           nxt_idx;
  logic [WORD_SIZE:0]   nxt_mag;
  logic [WORD_SIZE-1:0] nxt_re, nxt_im;

  localparam logic [WORD_SIZE:0] ONE = {{WORD_SIZE{1'b0}}, 1'b1};

  // Abs is taken one bit wider than the sample so -2^(W-1) maps to +2^(W-1).
  always_comb begin
    re_ext   = {i_harmonic_re[WORD_SIZE-1], i_harmonic_re};
    im_ext   = {i_harmonic_im[WORD_SIZE-1], i_harmonic_im};
    abs_re   = re_ext[WORD_SIZE] ? (~re_ext + ONE) : re_ext;
    abs_im   = im_ext[WORD_SIZE] ? (~im_ext + ONE) : im_ext;
    cand_mag = abs_re + abs_im;
    take     = (k == 2'd0) || (cand_mag > best_mag);
    nxt_idx  = take ? k             : best_idx;
    nxt_mag  = take ? cand_mag      : best_mag;
    nxt_re   = take ? i_harmonic_re : best_re;
    nxt_im   = take ? i_harmonic_im : best_im;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: if (i_start) next_state = SCAN;
      SCAN: begin
        o_busy = 1'b1;
        if (k == 2'd3) next_state = DONE;
      end
      DONE: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The last scan step folds its own candidate straight into the peak outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k          <= 2'd0;
      best_idx   <= 2'd0;
      best_mag   <= '0;
      best_re    <= '0;
      best_im    <= '0;
      o_peak_idx <= 2'd0;
      o_peak_mag <= '0;
      o_peak_re  <= '0;
      o_peak_im  <= '0;
    end else if (state == SCAN) begin
      k        <= k + 2'd1;
      best_idx <= nxt_idx;
      best_mag <= nxt_mag;
      best_re  <= nxt_re;
      best_im  <= nxt_im;
      if (k == 2'd3) begin
        o_peak_idx <= nxt_idx;
        o_peak_mag <= nxt_mag;
        o_peak_re  <= nxt_re;
        o_peak_im  <= nxt_im;
      end
    end else begin
      k <= 2'd0;
    end
  end

  assign o_select = k;

endmodule
